if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch front end of the five-stage MIPS pipeline, directly upstream of the ID stage and control unit. Holds the PC/nPC register pair, drives the instruction memory address, and latches the fetched word plus its PC into the IF/ID pipeline register. It supports:
- hazard stalls, via independent load enables;
- taken-branch redirection, with a one-instruction delay slot;
- IF/ID squash.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 9: instruction memory byte-address width.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- le_pc, input, 1: PC/nPC load enable. 0 means stall and hold.
- le_ifid, input, 1: IF/ID register load enable. 0 means hold.
- flush, input, 1: squash IF/ID to NOP.
- branch_taken, input, 1: ID-stage branch/jump resolved taken.
- branch_target, input, 32: byte address of the branch/jump target.
- imem_data, input, 32: instruction word returned by instruction memory (combinational read).
- imem_addr, output, ADDR_W: instruction memory byte address; equals pc_out[ADDR_W-1:0].
- pc_out, output, 32: current PC.
- npc_out, output, 32: next PC.
- if_id_instr, output, 32: instruction presented to ID.
- if_id_pc, output, 32: PC of if_id_instr, used for link address = if_id_pc+8.
- if_id_valid, output, 1: if_id_instr is a real fetched instruction.
- fetch_count, output, 16: saturating count of instructions loaded into IF/ID.

## Operation
Reset has priority over every other input. On a clock edge with reset=1:
- pc_out ← RESET_PC and npc_out ← RESET_PC+4;
- if_id_instr, if_id_pc and fetch_count ← 0;
- if_id_valid ← 0.

PC/nPC update, when reset=0:
- le_pc=1, branch_taken=0: pc ← npc and npc ← npc+4.
- le_pc=1, branch_taken=1: pc ← {branch_target[31:2],2'b00} and npc ← {branch_target[31:2],2'b00}+4.
  - The instruction at the old pc is the delay slot. It is latched into IF/ID on the same edge (when le_ifid=1) and executes normally.
- le_pc=0: pc and npc hold. branch_taken is ignored. The hazard unit keeps the branch in ID until le_pc=1.
- All PC arithmetic is modulo 2^32, so npc=32'hFFFF_FFFC yields next npc=0. Bits [1:0] of pc and npc are always 0.

IF/ID register, when reset=0, in priority order:
1. flush=1: if_id_instr ← 32'h0 (NOP), if_id_pc ← 0, if_id_valid ← 0. Applies regardless of le_ifid.
2. le_ifid=1: if_id_instr ← imem_data, if_id_pc ← pc_out, if_id_valid ← 1.
3. Otherwise hold.

fetch_count:
- Increments by 1 on each edge where reset=0, flush=0 and le_ifid=1.
- Saturates at 16'hFFFF.

imem_addr is purely combinational from pc_out. There are no other combinational input-to-output paths.

## Timing
- Fetch latency: imem_data for pc_out appears on if_id_instr one edge later.
- Branch redirect: the branch in ID with branch_taken=1 at edge N causes:
  - the delay slot to be in IF/ID after edge N;
  - the target to be on imem_addr after edge N;
  - the target instruction to be in IF/ID after edge N+1.
- Stall: with le_pc=0 and le_ifid=0, all outputs are unchanged for every held cycle. Stalls of any length are legal.
- Load-use bubble: le_pc=0, le_ifid=0, with the control-path mux inserting the NOP downstream. This block needs no special state for it.
- Reset mid-stall or mid-branch: reset wins and all state returns to reset values on that edge.
- After reset deasserts, the first edge with le_pc=le_ifid=1 fetches RESET_PC into IF/ID.

## Test plan
- Sequential fetch: reset with RESET_PC=0, then le_pc=le_ifid=1 for 4 edges with imem_data=32'h1111_0000+pc. Required: pc sequence 4,8,12,16, if_id_pc 0,4,8,12, if_id_valid=1, fetch_count=4.
- Stall: at pc=8, hold le_pc=le_ifid=0 for 3 edges. Required: pc=8, npc=12 and IF/ID unchanged throughout. Release: next edge pc=12, if_id_pc=8.
- Taken branch: at pc=12, branch_taken=1 with branch_target=32'h40 at one edge. Required: if_id_pc=12 (delay slot), pc=32'h40, npc=32'h44. Next edge: if_id_pc=32'h40.
- Flush priority: flush=1 and le_ifid=1 on the same edge. Required: if_id_instr=0, if_id_valid=0, fetch_count unchanged, pc still advances.
- Boundary: RESET_PC=32'hFFFF_FFF8. Required: after two advancing edges pc=0 and npc=4. Misaligned branch_target=32'h23 gives pc=32'h20. Forcing fetch_count to 16'hFFFF gives a hold at 16'hFFFF.
- Reset mid-operation: assert reset during a stall with a branch pending. Required: next edge gives pc=RESET_PC, if_id_valid=0, fetch_count=0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch unit's control, instruction-memory and IF/ID signals.
//   slave  modport : the fetch unit (takes controls and imem_data, drives the rest)
//   master modport : the surrounding pipeline (hazard unit, ID stage, imem)
// Signals:
//   le_pc, le_ifid, flush      hazard/control-path enables and squash
//   branch_taken, branch_target ID-stage redirect request
//   imem_data / imem_addr      combinational instruction memory read
//   pc_out, npc_out            PC/nPC register pair
//   if_id_instr/pc/valid       IF/ID pipeline register contents
//   fetch_count                saturating count of IF/ID loads
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int ADDR_W = 9
);
  logic              le_pc;
  logic              le_ifid;
  logic              flush;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       imem_data;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       pc_out;
  logic [31:0]       npc_out;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic              if_id_valid;
  logic [15:0]       fetch_count;

  modport slave (
    input  le_pc, le_ifid, flush, branch_taken, branch_target, imem_data,
    output imem_addr, pc_out, npc_out, if_id_instr, if_id_pc, if_id_valid,
           fetch_count
  );

  modport master (
    output le_pc, le_ifid, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, pc_out, npc_out, if_id_instr, if_id_pc, if_id_valid,
           fetch_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// MIPS instruction-fetch front end: PC/nPC pair, instruction memory address,
// and the IF/ID pipeline register. Taken branches redirect with one delay
// slot (the word at the old PC is latched on the redirect edge).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides every other input
//   bus    if_fetch_unit_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input  logic          clk,
  input  logic          reset,
  if_fetch_unit_if.slave bus
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] npc_q,   npc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q,  ifpc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic [31:0] target_aligned;
  logic        load_ifid;

  // Word-align the redirect target; the low two bits are never meaningful.
  assign target_aligned = {bus.branch_target[31:2], 2'b00};
  assign load_ifid      = bus.le_ifid && !bus.flush;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    count_d = count_q;

    // While stalled (le_pc=0) the branch stays in ID, so branch_taken is ignored.
    if (bus.le_pc) begin
      if (bus.branch_taken) begin
        pc_d  = target_aligned;
        npc_d = target_aligned + 32'd4;
      end else begin
        pc_d  = npc_q;
        npc_d = npc_q + 32'd4;
      end
    end

    // Squash beats load; the old PC's word is the delay slot on a redirect.
    if (bus.flush) begin
      instr_d = 32'h0;
      ifpc_d  = 32'h0;
      valid_d = 1'b0;
    end else if (bus.le_ifid) begin
      instr_d = bus.imem_data;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
    end

    if (load_ifid && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs before any of them change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      instr_q <= 32'h0;
      ifpc_q  <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 16'h0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q[ADDR_W-1:0];
  assign bus.pc_out      = pc_q;
  assign bus.npc_out     = npc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_count = count_q;

  // Target bits [1:0] are intentionally discarded by the alignment above.
  logic unused_target_lsbs;
  assign unused_target_lsbs = &{1'b0, bus.branch_target[1:0]};

endmodule
